// File: rtl/multdiv_issue_ctrl_pkg.sv
// multdiv_issue_ctrl_pkg: state encoding and writeback codes shared by the multdiv issue controller.
package multdiv_issue_ctrl_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_t;
  localparam int RSTATUS_DEF  = 30;
  localparam int MUL_OVF_DEF  = 4;
  localparam int DIV0_DEF     = 5;
  localparam int TIMEOUT_DEF  = 7;
endpackage

// File: rtl/mdctl_wait_counter.sv
// mdctl_wait_counter: cycle counter with sync clear, enable and a terminal-count flag.
module mdctl_wait_counter #(
  parameter int W = 7,
  parameter int TERM = 63
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         term
);
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign term = cnt == W'(TERM);
endmodule

// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl: issues one mult/div to multdiv, stalls until its result, then writes back once.
module multdiv_issue_ctrl
  import multdiv_issue_ctrl_pkg::*;
#(
  parameter int TIMEOUT      = 64,
  parameter int MIN_WAIT     = 2,
  parameter int RSTATUS_REG  = RSTATUS_DEF,
  parameter int MUL_OVF_CODE = MUL_OVF_DEF,
  parameter int DIV0_CODE    = DIV0_DEF,
  parameter int TIMEOUT_CODE = TIMEOUT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_is_div,
  input  logic [31:0] in_opA,
  input  logic [31:0] in_opB,
  input  logic [4:0]  in_rd,
  input  logic        flush,
  output logic        stall,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  state_t state;
  logic is_div_q;
  logic [4:0] rd_q;
  logic [CW-1:0] cnt;
  logic term, accept, rdy_ok, timed_out, exc;
  mdctl_wait_counter #(.W(CW), .TERM(TIMEOUT - 1)) u_cnt (
    .clock(clock),
    .reset(reset),
    .clr(state == S_ISSUE),
    .en(state == S_WAIT),
    .cnt(cnt),
    .term(term)
  );
  assign accept    = state == S_IDLE && in_valid && !flush;
  // RDY inside the first MIN_WAIT cycles may still belong to the previous op
  assign rdy_ok    = state == S_WAIT && md_resultRDY && cnt >= CW'(MIN_WAIT);
  assign timed_out = state == S_WAIT && term && !rdy_ok;
  assign exc       = rdy_ok && md_exception;
  assign stall     = accept || state == S_ISSUE || state == S_WAIT;
  assign busy      = state != S_IDLE;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      is_div_q     <= 1'b0;
      rd_q         <= '0;
      md_ctrl_MULT <= 1'b0;
      md_ctrl_DIV  <= 1'b0;
      md_operandA  <= '0;
      md_operandB  <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
    end else begin
      md_ctrl_MULT <= accept && !in_is_div;
      md_ctrl_DIV  <= accept && in_is_div;
      wb_valid     <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          state       <= S_ISSUE;
          md_operandA <= in_opA;
          md_operandB <= in_opB;
          rd_q        <= in_rd;
          is_div_q    <= in_is_div;
        end
        S_ISSUE: state <= flush ? S_IDLE : S_WAIT;
        S_WAIT: if (flush) state <= S_IDLE;
          else if (rdy_ok || timed_out) begin
            state    <= S_WB;
            wb_valid <= timed_out || exc || rd_q != 5'd0;
            wb_rd    <= (timed_out || exc) ? 5'(RSTATUS_REG) : rd_q;
            wb_data  <= timed_out ? 32'(TIMEOUT_CODE) :
                        exc ? (is_div_q ? 32'(DIV0_CODE) : 32'(MUL_OVF_CODE)) : md_result;
          end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// tb_multdiv_issue_ctrl: directed checks of issue, min-wait, exceptions, flush, timeout and reset.
module tb_multdiv_issue_ctrl;
  logic clock = 0, reset = 1, in_valid = 0, in_is_div = 0, flush = 0;
  logic md_exception = 0, md_resultRDY = 0;
  logic [31:0] in_opA = 0, in_opB = 0, md_result = 0;
  logic [4:0] in_rd = 0;
  logic stall, md_ctrl_MULT, md_ctrl_DIV, wb_valid, busy;
  logic [31:0] md_operandA, md_operandB, wb_data;
  logic [4:0] wb_rd;
  int checks = 0, failures = 0, mult_pulses = 0, p0;

  multdiv_issue_ctrl dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_is_div(in_is_div),
    .in_opA(in_opA), .in_opB(in_opB), .in_rd(in_rd), .flush(flush), .stall(stall),
    .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV), .md_operandA(md_operandA),
    .md_operandB(md_operandB), .md_result(md_result), .md_exception(md_exception),
    .md_resultRDY(md_resultRDY), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy)
  );

  always #5 clock = ~clock;
  always @(negedge clock) mult_pulses += int'(md_ctrl_MULT);

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic start(logic d, logic [31:0] a, logic [31:0] b, logic [4:0] r);
    in_valid = 1; in_is_div = d; in_opA = a; in_opB = b; in_rd = r;
    @(negedge clock);
    in_valid = 0;
  endtask

  initial begin
    step(2);
    chk("rst_stall", stall, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_mult", md_ctrl_MULT, 0);
    chk("rst_opA", md_operandA, 0);
    reset = 0;
    step(1);
    // mult 6 x 7 -> r5
    p0 = mult_pulses;
    in_valid = 1; in_is_div = 0; in_opA = 6; in_opB = 7; in_rd = 5;
    #1;
    chk("t1_accept_stall", stall, 1);
    chk("t1_idle_busy", busy, 0);
    @(negedge clock);
    in_valid = 0;
    chk("t1_mult_pulse", md_ctrl_MULT, 1);
    chk("t1_div_pulse", md_ctrl_DIV, 0);
    chk("t1_opA", md_operandA, 6);
    chk("t1_opB", md_operandB, 7);
    step(1);
    chk("t1_pulse_gone", md_ctrl_MULT, 0);
    chk("t1_wait_stall", stall, 1);
    step(2);
    md_resultRDY = 1; md_result = 42;
    step(1);
    chk("t1_wb_valid", wb_valid, 1);
    chk("t1_wb_rd", wb_rd, 5);
    chk("t1_wb_data", wb_data, 42);
    chk("t1_wb_stall", stall, 0);
    chk("t1_one_pulse", mult_pulses - p0, 1);
    md_resultRDY = 0;
    step(1);
    chk("t1_after_wb", wb_valid, 0);
    chk("t1_idle", busy, 0);
    // div 100 / 0 -> exception into r30
    start(1, 100, 0, 3);
    chk("t2_div_pulse", md_ctrl_DIV, 1);
    chk("t2_mult_pulse", md_ctrl_MULT, 0);
    md_resultRDY = 1; md_exception = 1; md_result = 0;
    step(3);
    chk("t2_min_wait", wb_valid, 0);
    step(1);
    chk("t2_wb_valid", wb_valid, 1);
    chk("t2_wb_rd", wb_rd, 30);
    chk("t2_wb_data", wb_data, 5);
    // offered during WB: must be ignored, then accepted in the following idle cycle
    in_valid = 1; in_is_div = 0; in_opA = 32'h4000_0000; in_opB = 4; in_rd = 8;
    step(1);
    chk("t3_ignored_in_wb", busy, 0);
    chk("t3_idle_accept_stall", stall, 1);
    start(0, 32'h4000_0000, 4, 8);
    chk("t3_opA", md_operandA, 32'h4000_0000);
    chk("t3_mult_pulse", md_ctrl_MULT, 1);
    step(3);
    chk("t3_min_wait", wb_valid, 0);
    step(1);
    chk("t3_wb_valid", wb_valid, 1);
    chk("t3_wb_rd", wb_rd, 30);
    chk("t3_wb_data", wb_data, 4);
    // stale RDY held across ops must not be taken early
    md_exception = 0; md_result = 32'h111;
    step(1);
    start(0, 3, 5, 7);
    step(3);
    chk("t4_stale_ignored", wb_valid, 0);
    md_result = 15;
    step(1);
    chk("t4_wb_valid", wb_valid, 1);
    chk("t4_wb_rd", wb_rd, 7);
    chk("t4_wb_data", wb_data, 15);
    md_resultRDY = 0;
    step(1);
    // flush two cycles after issue of div 9/3
    start(1, 9, 3, 4);
    step(2);
    flush = 1; md_resultRDY = 1; md_result = 3;
    step(1);
    flush = 0;
    chk("t5_flush_idle", busy, 0);
    chk("t5_flush_no_wb", wb_valid, 0);
    chk("t5_flush_no_stall", stall, 0);
    step(2);
    chk("t5_late_rdy_no_wb", wb_valid, 0);
    md_result = 6;
    start(0, 2, 3, 6);
    step(4);
    chk("t5_wb_valid", wb_valid, 1);
    chk("t5_wb_rd", wb_rd, 6);
    chk("t5_wb_data", wb_data, 6);
    md_resultRDY = 0;
    step(1);
    // rd = 0 without exception: no writeback strobe
    start(0, 1, 1, 0);
    md_resultRDY = 1; md_result = 1;
    step(4);
    chk("t6_rd0_suppressed", wb_valid, 0);
    chk("t6_rd0_in_wb", busy, 1);
    md_resultRDY = 0;
    step(1);
    // RDY never comes: timeout after 64 WAIT cycles
    start(0, 1, 1, 9);
    step(64);
    chk("t7_before_timeout", wb_valid, 0);
    chk("t7_still_busy", busy, 1);
    step(1);
    chk("t7_to_valid", wb_valid, 1);
    chk("t7_to_rd", wb_rd, 30);
    chk("t7_to_data", wb_data, 7);
    step(1);
    // asynchronous reset mid-WAIT
    start(1, 8, 2, 2);
    step(5);
    reset = 1;
    #1;
    chk("t8_rst_stall", stall, 0);
    chk("t8_rst_busy", busy, 0);
    chk("t8_rst_opA", md_operandA, 0);
    chk("t8_rst_opB", md_operandB, 0);
    chk("t8_rst_wb_rd", wb_rd, 0);
    chk("t8_rst_wb_data", wb_data, 0);
    chk("t8_rst_div", md_ctrl_DIV, 0);
    @(negedge clock);
    reset = 0; md_resultRDY = 1; md_result = 4;
    step(4);
    chk("t8_no_wb_after_rst", wb_valid, 0);
    chk("t8_idle_after_rst", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
